ga_fitness_engine: RTL and testbench



---
 rtl/ga_fitness_engine.sv | 163 ++++++++++++++++
 tb/tb_ga_fitness_engine.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ga_fitness_engine.sv
// rtl/ga_fitness_engine.sv - GA fitness stage: FIR evaluation with hard-tanh and absolute-error scoring
module ga_fitness_engine #(
    parameter int DATA_INT_W   = 1,
    parameter int DATA_FRACT_W = 5,
    parameter int DATA_W       = DATA_INT_W + DATA_FRACT_W,
    parameter int M_MAX        = 32,
    parameter int B_MAX        = 64,
    parameter int B_MAX_W      = $clog2(B_MAX + 1),
    parameter int B_IDX_MAX_W  = $clog2(B_MAX),
    parameter int CHROM_MAX_W  = DATA_W * M_MAX,
    parameter int FIT_SCORE_W  = $clog2(2 * B_MAX + 1) + 2 * DATA_FRACT_W
) (
    input  logic                   clk,
    input  logic                   sw_rst,
    input  logic [B_MAX_W-1:0]     cnfg_b,
    output logic [FIT_SCORE_W-1:0] cnfg_max_fit_socre,
    input  logic                   fit_enable,
    input  logic [DATA_W-1:0]      i_vd_buff_d,
    input  logic [CHROM_MAX_W-1:0] i_vd_buff_v_vec_falt,
    output logic                   o_vd_buff_rd_req,
    output logic [B_IDX_MAX_W-1:0] o_vd_buff_rd_idx,
    input  logic                   queue_not_empty,
    input  logic [CHROM_MAX_W-1:0] queue_chromosome,
    output logic                   queue_pop,
    input  logic                   fit_ack,
    output logic                   fit_valid,
    output logic [CHROM_MAX_W-1:0] fit_chrom,
    output logic [FIT_SCORE_W-1:0] fit_score
);

    localparam int PROD_W   = 2 * DATA_W;
    localparam int SUM_W    = PROD_W + $clog2(M_MAX) + 1;
    localparam int ERR_W    = 2 * DATA_FRACT_W + 3;
    localparam int SCORE_SH = 1 + 2 * DATA_FRACT_W;

    localparam logic signed [SUM_W-1:0] Y_MAX = SUM_W'((1 << (2 * DATA_FRACT_W)) - 1);
    localparam logic signed [SUM_W-1:0] Y_MIN = ~Y_MAX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                   state_q;
    logic [B_MAX_W-1:0]       beff_d;
    logic [B_MAX_W-1:0]       beff_q;
    logic                     rd_req_q;
    logic [B_IDX_MAX_W-1:0]   rd_idx_q;
    logic                     acc_en_q;
    logic [FIT_SCORE_W-1:0]   acc_q;
    logic [FIT_SCORE_W-1:0]   acc_d;
    logic                     fit_valid_q;
    logic [CHROM_MAX_W-1:0]   fit_chrom_q;
    logic [FIT_SCORE_W-1:0]   fit_score_q;
    logic [FIT_SCORE_W-1:0]   max_score_q;

    logic signed [PROD_W-1:0] prod [M_MAX];
    logic signed [SUM_W-1:0]  y;
    logic signed [SUM_W-1:0]  y_sat;
    logic signed [ERR_W-1:0]  d_sh;
    logic signed [ERR_W-1:0]  err;
    logic [ERR_W-1:0]         abs_err;
    logic                     pop;

    always_comb begin
        beff_d = cnfg_b;
        if (cnfg_b == '0) begin
            beff_d = B_MAX_W'(1);
        end else if (cnfg_b > B_MAX_W'(B_MAX)) begin
            beff_d = B_MAX_W'(B_MAX);
        end
    end

    assign cnfg_max_fit_socre = FIT_SCORE_W'(beff_d) << SCORE_SH;

    // Full-precision sum: wide enough that all M_MAX products at -1*-1 cannot overflow.
    always_comb begin
        y = '0;
        for (int i = 0; i < M_MAX; i++) begin
            prod[i] = $signed(fit_chrom_q[i*DATA_W +: DATA_W])
                    * $signed(i_vd_buff_v_vec_falt[i*DATA_W +: DATA_W]);
            y = y + SUM_W'(prod[i]);
        end
    end

    always_comb begin
        y_sat = y;
        if (y > Y_MAX) begin
            y_sat = Y_MAX;
        end else if (y < Y_MIN) begin
            y_sat = Y_MIN;
        end
    end

    assign d_sh    = ERR_W'($signed(i_vd_buff_d)) <<< DATA_FRACT_W;
    assign err     = d_sh - ERR_W'(y_sat);
    assign abs_err = err[ERR_W-1] ? ERR_W'(-err) : ERR_W'(err);
    assign acc_d   = acc_q + (acc_en_q ? FIT_SCORE_W'(abs_err) : '0);

    assign pop = (state_q == S_IDLE) && fit_enable && queue_not_empty && !sw_rst;

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            state_q     <= S_IDLE;
            beff_q      <= B_MAX_W'(1);
            rd_req_q    <= 1'b0;
            rd_idx_q    <= '0;
            acc_en_q    <= 1'b0;
            acc_q       <= '0;
            fit_valid_q <= 1'b0;
            fit_chrom_q <= '0;
            fit_score_q <= '0;
            max_score_q <= '0;
        end else begin
            acc_en_q <= rd_req_q;
            acc_q    <= acc_d;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        state_q     <= S_READ;
                        fit_chrom_q <= queue_chromosome;
                        beff_q      <= beff_d;
                        max_score_q <= FIT_SCORE_W'(beff_d) << SCORE_SH;
                        rd_req_q    <= 1'b1;
                        rd_idx_q    <= '0;
                        acc_q       <= '0;
                    end
                end
                S_READ: begin
                    if (B_MAX_W'(rd_idx_q) == beff_q - B_MAX_W'(1)) begin
                        rd_req_q <= 1'b0;
                        state_q  <= S_DRAIN;
                    end else begin
                        rd_idx_q <= rd_idx_q + B_IDX_MAX_W'(1);
                    end
                end
                S_DRAIN: begin
                    // acc_d already contains the final sample's error here.
                    state_q     <= S_DONE;
                    fit_valid_q <= 1'b1;
                    fit_score_q <= max_score_q - acc_d;
                end
                S_DONE: begin
                    if (fit_ack) begin
                        fit_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign queue_pop        = pop;
    assign o_vd_buff_rd_req = rd_req_q;
    assign o_vd_buff_rd_idx = rd_idx_q;
    assign fit_valid        = fit_valid_q;
    assign fit_chrom        = fit_chrom_q;
    assign fit_score        = fit_score_q;

endmodule

// File: tb/tb_ga_fitness_engine.sv
// tb/tb_ga_fitness_engine.sv - scoreboard bench for ga_fitness_engine
module tb_ga_fitness_engine;

    localparam int DW = 6;
    localparam int BW = 7;
    localparam int IW = 6;
    localparam int CW = 192;
    localparam int SW = 18;

    logic          clk = 1'b0;
    logic          sw_rst;
    logic [BW-1:0] cnfg_b;
    logic [SW-1:0] max_fit;
    logic          fit_enable;
    logic [DW-1:0] vd_d;
    logic [CW-1:0] vd_v;
    logic          rd_req;
    logic [IW-1:0] rd_idx;
    logic          qne;
    logic [CW-1:0] qchrom;
    logic          qpop;
    logic          fit_ack;
    logic          fvalid;
    logic [CW-1:0] fchrom;
    logic [SW-1:0] fscore;

    always #5 clk = ~clk;

    ga_fitness_engine dut (
        .clk                  (clk),
        .sw_rst               (sw_rst),
        .cnfg_b               (cnfg_b),
        .cnfg_max_fit_socre   (max_fit),
        .fit_enable           (fit_enable),
        .i_vd_buff_d          (vd_d),
        .i_vd_buff_v_vec_falt (vd_v),
        .o_vd_buff_rd_req     (rd_req),
        .o_vd_buff_rd_idx     (rd_idx),
        .queue_not_empty      (qne),
        .queue_chromosome     (qchrom),
        .queue_pop            (qpop),
        .fit_ack              (fit_ack),
        .fit_valid            (fvalid),
        .fit_chrom            (fchrom),
        .fit_score            (fscore)
    );

    typedef struct {
        logic [CW-1:0] chrom;
        logic [SW-1:0] score;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            rd_cnt = 0;
    bit            drop_en = 1'b0;
    logic [CW-1:0] vmem [64];
    logic [DW-1:0] dmem [64];
    logic [CW-1:0] allneg;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic fill(input logic [DW-1:0] d, input logic [CW-1:0] v);
        for (int i = 0; i < 64; i++) begin
            dmem[i] = d;
            vmem[i] = v;
        end
    endtask

    // Buffer model: a request seen in cycle t is answered during cycle t+1.
    logic          pend_v = 1'b0;
    logic [IW-1:0] pend_idx = '0;
    always @(negedge clk) begin
        if (pend_v) begin
            vd_v = vmem[pend_idx];
            vd_d = dmem[pend_idx];
        end
        pend_v   = rd_req;
        pend_idx = rd_idx;
        if (rd_req) begin
            check("rd_idx", CW'(rd_idx), CW'(rd_cnt));
            rd_cnt++;
        end
    end

    // Result monitor: compares each new fit_valid against the scoreboard.
    logic fv_prev = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (fvalid && !fv_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("fit_chrom", fchrom, mon_e.chrom);
                check("fit_score", CW'(fscore), CW'(mon_e.score));
            end
        end
        fv_prev = fvalid;
    end

    task automatic run_eval(input logic [CW-1:0] chrom, input logic [BW-1:0] b, input int nreads,
                            input logic [SW-1:0] exp_score, input int hold);
        int   t;
        exp_t e;
        cnfg_b = b;
        qchrom = chrom;
        qne    = 1'b1;
        rd_cnt = 0;
        #1;
        t = 0;
        while (!qpop && t < 20) begin
            step();
            t++;
        end
        check("pop_seen", CW'(qpop), 1);
        if (!qpop) return;
        e.chrom = chrom;
        e.score = exp_score;
        sb.push_back(e);
        step();
        qne = 1'b0;
        if (drop_en) fit_enable = 1'b0;
        t = 1;
        while (!fvalid && t < 200) begin
            step();
            t++;
        end
        check("valid_latency", CW'(t), CW'(nreads + 2));
        check("read_count", CW'(rd_cnt), CW'(nreads));
        for (int k = 0; k < hold; k++) begin
            step();
            check("hold_valid", CW'(fvalid), 1);
            check("hold_score", CW'(fscore), CW'(exp_score));
            check("hold_chrom", fchrom, chrom);
        end
    endtask

    task automatic do_ack();
        fit_ack = 1'b1;
        step();
        fit_ack = 1'b0;
        check("valid_clear", CW'(fvalid), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        sw_rst     = 1'b1;
        cnfg_b     = 7'd16;
        fit_enable = 1'b1;
        qne        = 1'b0;
        qchrom     = '0;
        fit_ack    = 1'b0;
        vd_d       = '0;
        vd_v       = '0;
        for (int i = 0; i < 32; i++) allneg[i*DW +: DW] = 6'b100000;
        fill(6'd1, 192'd2);
        repeat (3) step();
        check("rst_rd_req", CW'(rd_req), 0);
        check("rst_rd_idx", CW'(rd_idx), 0);
        check("rst_valid", CW'(fvalid), 0);
        check("rst_chrom", fchrom, 0);
        check("rst_score", CW'(fscore), 0);
        check("rst_pop", CW'(qpop), 0);
        sw_rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step();
            check("empty_no_pop", CW'(qpop), 0);
            check("empty_no_valid", CW'(fvalid), 0);
        end
        check("max_fit_16", CW'(max_fit), 32768);
        fit_ack = 1'b1;
        step();
        fit_ack = 1'b0;
        check("stray_ack", CW'(fvalid), 0);

        run_eval(192'd0, 7'd16, 16, 18'd32256, 7);
        do_ack();
        run_eval(192'd3, 7'd16, 16, 18'd32352, 0);

        // Back-to-back: queue ready at ack, pop expected in the next cycle.
        vmem[0] = 192'd31; dmem[0] = 6'd0;
        vmem[1] = 192'd0;  dmem[1] = 6'd1;
        cnfg_b = 7'd2;
        qchrom = 192'd32;
        qne    = 1'b1;
        fit_ack = 1'b1;
        step();
        fit_ack = 1'b0;
        check("chain_valid_clear", CW'(fvalid), 0);
        check("chain_pop", CW'(qpop), 1);
        run_eval(192'd32, 7'd2, 2, 18'd3072, 0);
        do_ack();

        fill(6'b100000, allneg);
        run_eval(allneg, 7'd64, 64, 18'd64, 2);
        check("max_fit_64", CW'(max_fit), 131072);
        do_ack();

        fill(6'd1, 192'd2);
        run_eval(192'd0, 7'd0, 1, 18'd2016, 0);
        check("max_fit_b0", CW'(max_fit), 2048);
        do_ack();
        run_eval(192'd0, 7'd100, 64, 18'd129024, 0);
        check("max_fit_b100", CW'(max_fit), 131072);
        do_ack();

        drop_en = 1'b1;
        run_eval(192'd3, 7'd16, 16, 18'd32352, 1);
        qne = 1'b1;
        do_ack();
        for (int i = 0; i < 5; i++) begin
            check("disabled_no_pop", CW'(qpop), 0);
            check("disabled_no_valid", CW'(fvalid), 0);
            step();
        end
        qne = 1'b0;
        drop_en = 1'b0;
        fit_enable = 1'b1;

        // Reset in the middle of READ.
        cnfg_b = 7'd16;
        qchrom = 192'd3;
        qne    = 1'b1;
        rd_cnt = 0;
        #1;
        for (int t = 0; t < 20 && !qpop; t++) step();
        check("rst_test_pop", CW'(qpop), 1);
        repeat (3) step();
        check("rst_test_reading", CW'(rd_req), 1);
        sw_rst = 1'b1;
        step();
        check("midrst_rd_req", CW'(rd_req), 0);
        check("midrst_rd_idx", CW'(rd_idx), 0);
        check("midrst_valid", CW'(fvalid), 0);
        check("midrst_pop", CW'(qpop), 0);
        check("midrst_chrom", fchrom, 0);
        check("midrst_score", CW'(fscore), 0);
        qne    = 1'b0;
        sw_rst = 1'b0;
        repeat (3) step();
        check("sb_drained", CW'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
